muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issue stage and muldiv_unit.
// The master drives the op request. The slave returns busy/done and the HI/LO state.
// No storage here; the unit registers every response signal.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; MTHI/MTLO write in one edge.
// Latency WIDTH+1 cycles from accepted start to done (1 for multiply with MULDIV_FAST_MULT_EN).
// Requests are ignored while busy; the issuing pipeline must stall MFHI/MFLO meanwhile.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Upper half: partial product / remainder. Lower half: multiplier / dividend -> quotient.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Multiplicand or divisor magnitude.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  // Raw dividend, kept for the divide-by-zero HI result.
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic               is_div_q, is_div_d;
  logic               neg_p_q, neg_p_d;   // product / quotient sign
  logic               neg_r_q, neg_r_d;   // remainder sign
  logic               dz_q, dz_d;         // in-flight op is a divide by zero
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Operand conditioning at acceptance
  logic               sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  assign sgn_op = ~bus.op[0];
  assign a_neg  = sgn_op & bus.a[WIDTH-1];
  assign b_neg  = sgn_op & bus.b[WIDTH-1];
  assign a_mag  = a_neg ? -bus.a : bus.a;
  assign b_mag  = b_neg ? -bus.b : bus.b;

  // One shift-add multiply step
  logic [WIDTH:0]     mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

  // One restoring divide step: shift in next dividend bit, subtract if it fits
  logic [WIDTH:0]     div_sh, div_sub;
  logic               div_ge;
  assign div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, opnd_q};
  assign div_sub = div_sh - {1'b0, opnd_q};

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_p_q ? -acc_q : acc_q;
  assign quo_fix  = neg_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MULT_EN
  // Single multiplier covering both signednesses via one extra extension bit
  logic signed [2*WIDTH+1:0] fast_prod;
  assign fast_prod = $signed({a_neg, bus.a}) * $signed({b_neg, bus.b});
`endif

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      araw_q   <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      araw_q   <= araw_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  // Next-state: iterative ops go IDLE -> RUN (WIDTH steps) -> FIX -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.op[2]) begin
`ifdef MULDIV_FAST_MULT_EN
          if (bus.op[1]) state_d = S_RUN;
`else
          state_d = S_RUN;
`endif
        end
      end
      S_RUN:   if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and outputs: latch operands, iterate, then sign-fix and commit HI/LO
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    araw_d   = araw_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (!bus.op[2]) begin
`ifdef MULDIV_FAST_MULT_EN
            if (!bus.op[1]) begin
              {hi_d, lo_d} = fast_prod[2*WIDTH-1:0];
              done_d       = 1'b1;
              dbz_d        = 1'b0;
            end else
`endif
            begin
              cnt_d    = '0;
              is_div_d = bus.op[1];
              araw_d   = bus.a;
              neg_p_d  = a_neg ^ b_neg;
              neg_r_d  = a_neg;
              dz_d     = bus.op[1] && (bus.b == '0);
              if (bus.op[1]) begin
                acc_d  = {{WIDTH{1'b0}}, a_mag};
                opnd_d = b_mag;
              end else begin
                acc_d  = {{WIDTH{1'b0}}, b_mag};
                opnd_d = a_mag;
              end
            end
          end else if (bus.op[1:0] == 2'b00) begin
            hi_d = bus.a;
          end else if (bus.op[1:0] == 2'b01) begin
            lo_d = bus.a;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div_q) begin
          if (div_ge) acc_d = {div_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else        acc_d = {div_sh[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        done_d = 1'b1;
        dbz_d  = dz_q;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (dz_q) begin
          lo_d = '1;
          hi_d = araw_q;
        end else begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end
      end
      default: ;
    endcase
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand sequences, random vs model.
// Expected latency follows MULDIV_FAST_MULT_EN when the bench is built with it.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, SV division truncates toward zero
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      3'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        hi = p[63:32];
        lo = p[31:0];
      end
      3'd1: begin
        p  = {32'b0, a} * {32'b0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          dz = 1'b1;
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          if (op == 3'd2) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
          end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
          end
          q  = sa / sb;
          r  = sa % sb;
          p  = q;
          lo = p[31:0];
          p  = r;
          hi = p[31:0];
        end
      end
    endcase
  endfunction

  // Caller is at a falling edge; request is presented for exactly one rising edge
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                           input logic edz, input bit pulse);
    int   lat;
    int   exp_lat;
    bit   seen;
    logic busy1;
    lat   = 0;
    seen  = 1'b0;
    busy1 = 1'b0;
    start_op(op, a, b);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 0) busy1 = bus.busy;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      lat++;
    end
    exp_lat = (FAST && !op[1]) ? 0 : W + 1;
    chk({name, "_done_seen"}, seen, 1);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_busy_after_start"}, busy1, (exp_lat != 0));
    chk({name, "_busy_at_done"}, bus.busy, 0);
    chk({name, "_hi"}, bus.hi, ehi);
    chk({name, "_lo"}, bus.lo, elo);
    chk({name, "_dbz"}, bus.div_by_zero, edz);
    if (pulse) begin
      @(negedge clk);
      chk({name, "_done_one_cycle"}, bus.done, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ehi, elo, sav_hi, sav_lo, ra, rb;
    logic        edz;
    logic [2:0]  rop;
    int          dpulses;
    bit          seen;

    tbl[0] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    tbl[1] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    tbl[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[3] = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0};
    tbl[4] = '{3'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1};
    tbl[5] = '{3'd2, 32'h0000_0006, 32'h0000_0003, 32'h0000_0000, 32'h0000_0002, 1'b0};
    tbl[6] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    tbl[7] = '{3'd0, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0};
    tbl[8] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    tbl[9] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};

    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_dbz", bus.div_by_zero, 0);
    chk("reset_hi", bus.hi, 0);
    chk("reset_lo", bus.lo, 0);

    // Directed vectors
    for (int i = 0; i < 10; i++)
      run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                tbl[i].hi, tbl[i].lo, tbl[i].dz, 1'b1);

    // MTHI / MTLO take effect at the accepting edge, no done
    sav_lo = bus.lo;
    start_op(3'd4, 32'h1234_5678, 32'h0);
    @(negedge clk);
    chk("mthi_hi", bus.hi, 32'h1234_5678);
    chk("mthi_lo_kept", bus.lo, sav_lo);
    chk("mthi_no_done", bus.done, 0);
    chk("mthi_no_busy", bus.busy, 0);
    sav_hi = bus.hi;
    start_op(3'd5, 32'hCAFE_0001, 32'h0);
    @(negedge clk);
    chk("mtlo_lo", bus.lo, 32'hCAFE_0001);
    chk("mtlo_hi_kept", bus.hi, sav_hi);
    chk("mtlo_no_done", bus.done, 0);

    // Reserved op codes change nothing
    sav_hi = bus.hi;
    sav_lo = bus.lo;
    start_op(3'd6, 32'hAAAA_AAAA, 32'h5555_5555);
    start_op(3'd7, 32'hBBBB_BBBB, 32'h0);
    @(negedge clk);
    chk("rsvd_busy", bus.busy, 0);
    chk("rsvd_done", bus.done, 0);
    chk("rsvd_hi", bus.hi, sav_hi);
    chk("rsvd_lo", bus.lo, sav_lo);

    // Requests while busy are ignored; HI/LO hold their old values during RUN
    sav_lo = bus.lo;
    start_op(3'd3, 32'd100, 32'd7);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("busy_lo_held", bus.lo, sav_lo);
    bus.op = 3'd0; bus.a = 32'h0000_1000; bus.b = 32'h0000_1000;
    @(negedge clk);
    bus.op = 3'd4;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("ign_done_seen", seen, 1);
    chk("ign_hi", bus.hi, 32'd2);
    chk("ign_lo", bus.lo, 32'd14);

    // Back-to-back: start issued in the done cycle is accepted
    run_check("b2b_first", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
    run_check("b2b_second", 3'd2, 32'd6, 32'd3, 32'd0, 32'd2, 1'b0, 1'b1);

    // Reset mid-RUN aborts without done
    start_op(3'd2, 32'h0000_1000, 32'd3);
    repeat (5) @(negedge clk);
    chk("midrun_busy", bus.busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    chk("abort_done", bus.done, 0);
    dpulses = 0;
    repeat (W + 5) begin
      @(negedge clk);
      if (bus.done) dpulses++;
    end
    chk("abort_no_done_pulse", dpulses, 0);
    run_check("after_abort_mult", 3'd0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b1);

    // Random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 100));
        default: ;
      endcase
      model(rop, ra, rb, ehi, elo, edz);
      run_check($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, ehi, elo, edz, (i % 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
